// File: rtl/instr_sequencer.sv
// Program-memory instruction sequencer: issues CALL/RET strobes to a downstream
// opcode stack while tracking its call depth, with free-run and single-step modes.
module instr_sequencer #(
   parameter int DEPTH      = 8,
   parameter int PROG_WORDS = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        load_en,
   input  logic [3:0]  load_addr,
   input  logic [13:0] load_word,
   input  logic        start,
   input  logic        step_mode,
   input  logic        step,
   output logic [3:0]  opcode,
   output logic [7:0]  data,
   output logic        CALLproc,
   output logic        RET,
   output logic        busy,
   output logic        done,
   output logic [1:0]  fault,
   output logic [3:0]  pc
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;
   localparam logic [1:0] S_FAULT = 2'd3;

   localparam logic [1:0] K_NOP  = 2'b00;
   localparam logic [1:0] K_CALL = 2'b01;
   localparam logic [1:0] K_RET  = 2'b10;
   localparam logic [1:0] K_HALT = 2'b11;

   localparam int             DW        = $clog2(DEPTH + 1);
   localparam logic [DW-1:0]  DEPTH_MAX = DW'(DEPTH);
   localparam logic [DW-1:0]  DEPTH_ONE = DW'(1);

   logic [13:0]   mem [PROG_WORDS];
   logic [1:0]    state;
   logic [DW-1:0] depth;
   logic [13:0]   word;
   logic          advance;

   assign word    = mem[pc];
   assign advance = (state == S_RUN) && (!step_mode || step);
   assign busy    = (state == S_RUN);
   assign done    = (state == S_DONE);

   // Program memory has no reset so a program survives a reset and can be rerun.
   always_ff @(posedge clock) begin
      if (!reset && state == S_IDLE && load_en)
         mem[load_addr] <= load_word;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= S_IDLE;
         pc       <= 4'd0;
         depth    <= '0;
         opcode   <= 4'd0;
         data     <= 8'd0;
         CALLproc <= 1'b0;
         RET      <= 1'b0;
         fault    <= 2'b00;
      end else begin
         // Outputs are single-cycle: cleared unless this edge issues something.
         opcode   <= 4'd0;
         data     <= 8'd0;
         CALLproc <= 1'b0;
         RET      <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state <= S_RUN;
                  pc    <= 4'd0;
                  depth <= '0;
               end
            end
            S_RUN: begin
               if (advance) begin
                  case (word[13:12])
                     K_NOP: begin
                        data <= word[7:0];
                        pc   <= pc + 4'd1;
                     end
                     K_CALL: begin
                        if (depth < DEPTH_MAX) begin
                           CALLproc <= 1'b1;
                           opcode   <= word[11:8];
                           data     <= word[7:0];
                           depth    <= depth + DEPTH_ONE;
                           pc       <= pc + 4'd1;
                        end else begin
                           state <= S_FAULT;
                           fault <= 2'b01;
                        end
                     end
                     K_RET: begin
                        if (depth != '0) begin
                           RET   <= 1'b1;
                           data  <= word[7:0];
                           depth <= depth - DEPTH_ONE;
                           pc    <= pc + 4'd1;
                        end else begin
                           state <= S_FAULT;
                           fault <= 2'b10;
                        end
                     end
                     default: begin
                        state <= S_DONE;
                        data  <= word[7:0];
                        pc    <= pc + 4'd1;
                     end
                  endcase
               end
            end
            S_DONE: begin
               if (start) begin
                  state <= S_RUN;
                  pc    <= 4'd0;
                  depth <= '0;
               end
            end
            default: begin
               state <= S_FAULT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed scenarios plus a randomized run checked
// against a call-stack reference model.
module tb_instr_sequencer;

   localparam int DEPTH = 8;

   logic        clock = 1'b0;
   logic        reset;
   logic        load_en;
   logic [3:0]  load_addr;
   logic [13:0] load_word;
   logic        start;
   logic        step_mode;
   logic        step;
   logic [3:0]  opcode;
   logic [7:0]  data;
   logic        CALLproc;
   logic        RET;
   logic        busy;
   logic        done;
   logic [1:0]  fault;
   logic [3:0]  pc;

   int nvec = 0;
   int nmis = 0;

   // Reference model state
   logic [13:0] mm [16];
   logic [3:0]  call_stack [$];
   logic        m_run = 1'b0, m_done = 1'b0;
   logic [1:0]  e_fault = 2'b00;
   logic [3:0]  e_pc = 4'd0, e_op = 4'd0;
   logic [7:0]  e_data = 8'd0;
   logic        e_call = 1'b0, e_ret = 1'b0;

   instr_sequencer #(.DEPTH(DEPTH), .PROG_WORDS(16)) dut (
      .clock(clock), .reset(reset), .load_en(load_en), .load_addr(load_addr),
      .load_word(load_word), .start(start), .step_mode(step_mode), .step(step),
      .opcode(opcode), .data(data), .CALLproc(CALLproc), .RET(RET),
      .busy(busy), .done(done), .fault(fault), .pc(pc)
   );

   always #5 clock = ~clock;

   function automatic logic [13:0] mk(input logic [1:0] k, input logic [3:0] op, input logic [7:0] d);
      return {k, op, d};
   endfunction

   // One clock edge; the model applies the same inputs the DUT sees at that edge.
   task automatic tick();
      logic        r  = reset;
      logic        le = load_en;
      logic [3:0]  la = load_addr;
      logic [13:0] lw = load_word;
      logic        s  = start;
      logic        sm = step_mode;
      logic        st = step;
      logic [13:0] w;
      @(posedge clock);
      e_op = 4'd0; e_data = 8'd0; e_call = 1'b0; e_ret = 1'b0;
      if (r) begin
         m_run = 1'b0; m_done = 1'b0; e_fault = 2'b00; e_pc = 4'd0;
         call_stack.delete();
      end else if (e_fault != 2'b00) begin
         // stuck until reset
      end else if (m_run) begin
         if (!sm || st) begin
            w = mm[e_pc];
            case (w[13:12])
               2'b00: begin e_data = w[7:0]; e_pc = e_pc + 4'd1; end
               2'b01: begin
                  if (call_stack.size() < DEPTH) begin
                     call_stack.push_back(w[11:8]);
                     e_call = 1'b1; e_op = w[11:8]; e_data = w[7:0]; e_pc = e_pc + 4'd1;
                  end else begin
                     m_run = 1'b0; e_fault = 2'b01;
                  end
               end
               2'b10: begin
                  if (call_stack.size() > 0) begin
                     void'(call_stack.pop_back());
                     e_ret = 1'b1; e_data = w[7:0]; e_pc = e_pc + 4'd1;
                  end else begin
                     m_run = 1'b0; e_fault = 2'b10;
                  end
               end
               default: begin
                  m_run = 1'b0; m_done = 1'b1; e_data = w[7:0]; e_pc = e_pc + 4'd1;
               end
            endcase
         end
      end else begin
         if (!m_done && le) mm[la] = lw;
         if (s) begin
            m_run = 1'b1; m_done = 1'b0; e_pc = 4'd0;
            call_stack.delete();
         end
      end
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; tick(); reset = 1'b0;
   endtask

   task automatic load(input logic [3:0] a, input logic [13:0] w);
      load_en = 1'b1; load_addr = a; load_word = w; tick();
      load_en = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      if ({opcode, data, CALLproc, RET, busy, done, fault, pc} !== 22'd0) begin
         nmis++;
         $display("FAIL reset_outputs got=%h want=0", {opcode, data, CALLproc, RET, busy, done, fault, pc});
      end
      nvec++;
   endtask

   task automatic test_call_ret();
      do_reset();
      load(4'd0, mk(2'b01, 4'd3, 8'h11));
      load(4'd1, mk(2'b10, 4'd0, 8'h22));
      load(4'd2, mk(2'b11, 4'd0, 8'h00));
      start = 1'b1; tick(); start = 1'b0;
      if ({busy, CALLproc, RET, pc} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
         nmis++; $display("FAIL start_edge got busy=%b call=%b ret=%b pc=%0d want 1 0 0 0", busy, CALLproc, RET, pc);
      end
      nvec++;
      tick();
      if ({CALLproc, RET, opcode, data} !== {1'b1, 1'b0, 4'd3, 8'h11}) begin
         nmis++; $display("FAIL call_issue got call=%b ret=%b op=%h d=%h want 1 0 3 11", CALLproc, RET, opcode, data);
      end
      nvec++;
      tick();
      if ({CALLproc, RET, opcode, data} !== {1'b0, 1'b1, 4'd0, 8'h22}) begin
         nmis++; $display("FAIL ret_issue got call=%b ret=%b op=%h d=%h want 0 1 0 22", CALLproc, RET, opcode, data);
      end
      nvec++;
      tick();
      if ({done, busy, CALLproc, RET, pc} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd3}) begin
         nmis++; $display("FAIL halt_done got done=%b busy=%b call=%b ret=%b pc=%0d want 1 0 0 0 3", done, busy, CALLproc, RET, pc);
      end
      nvec++;
   endtask

   task automatic test_overflow();
      int pulses = 0;
      do_reset();
      for (int i = 0; i < 9; i++) load(4'(i), mk(2'b01, 4'(i), 8'(i + 8'h80)));
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 9; i++) begin
         tick();
         if (CALLproc) pulses++;
      end
      if (pulses !== 8) begin
         nmis++; $display("FAIL overflow_pulses got=%0d want=8", pulses);
      end
      nvec++;
      if ({fault, busy, done, pc} !== {2'b01, 1'b0, 1'b0, 4'd8}) begin
         nmis++; $display("FAIL overflow_state got fault=%b busy=%b done=%b pc=%0d want 01 0 0 8", fault, busy, done, pc);
      end
      nvec++;
   endtask

   task automatic test_underflow();
      int rets = 0;
      do_reset();
      load(4'd0, mk(2'b10, 4'd0, 8'h5A));
      start = 1'b1; tick(); start = 1'b0;
      tick();
      if (RET) rets++;
      tick();
      if (RET) rets++;
      if ({rets[1:0], fault, pc, busy} !== {2'd0, 2'b10, 4'd0, 1'b0}) begin
         nmis++; $display("FAIL underflow got rets=%0d fault=%b pc=%0d busy=%b want 0 10 0 0", rets, fault, pc, busy);
      end
      nvec++;
      start = 1'b1; tick(); start = 1'b0; tick();
      if ({fault, busy, pc, RET} !== {2'b10, 1'b0, 4'd0, 1'b0}) begin
         nmis++; $display("FAIL fault_ignores_start got fault=%b busy=%b pc=%0d want 10 0 0", fault, busy, pc);
      end
      nvec++;
      do_reset();
      if ({fault, busy, done} !== 4'b0000) begin
         nmis++; $display("FAIL fault_reset got fault=%b busy=%b done=%b want 00 0 0", fault, busy, done);
      end
      nvec++;
      // IDLE accepts start again
      start = 1'b1; tick(); start = 1'b0;
      if (busy !== 1'b1) begin
         nmis++; $display("FAIL idle_after_reset got busy=%b want 1", busy);
      end
      nvec++;
      do_reset();
   endtask

   task automatic test_step_mode();
      int nsteps = 0, pulses = 0;
      logic exp_call;
      do_reset();
      load(4'd0, mk(2'b00, 4'd9, 8'h05));
      load(4'd1, mk(2'b01, 4'd7, 8'h33));
      load(4'd2, mk(2'b11, 4'd0, 8'h00));
      step_mode = 1'b1;
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step = (i % 3 == 2);
         if (step) nsteps++;
         tick();
         exp_call = step && (nsteps == 2);
         step = 1'b0;
         if (CALLproc) pulses++;
         if ({CALLproc, RET} !== {exp_call, 1'b0}) begin
            nmis++; $display("FAIL step_strobe cyc=%0d got call=%b ret=%b want %b 0", i, CALLproc, RET, exp_call);
         end
         nvec++;
      end
      if ({pulses[1:0], done, opcode} !== {2'd1, 1'b1, 4'd0}) begin
         nmis++; $display("FAIL step_summary got pulses=%0d done=%b op=%h want 1 1 0", pulses, done, opcode);
      end
      nvec++;
      step_mode = 1'b0;
   endtask

   task automatic test_wrap_and_reset();
      do_reset();
      for (int i = 0; i < 16; i++) load(4'(i), mk(2'b00, 4'd0, 8'(8'h40 + i)));
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 18; i++) begin
         tick();
         if ({busy, pc, data} !== {1'b1, 4'((i + 1) % 16), 8'(8'h40 + (i % 16))}) begin
            nmis++; $display("FAIL wrap_pc i=%0d got busy=%b pc=%0d d=%h want 1 %0d %h", i, busy, pc, data, (i + 1) % 16, 8'h40 + (i % 16));
         end
         nvec++;
      end
      do_reset();
      if ({opcode, data, CALLproc, RET, busy, done, fault, pc} !== 22'd0) begin
         nmis++; $display("FAIL midrun_reset got=%h want=0", {opcode, data, CALLproc, RET, busy, done, fault, pc});
      end
      nvec++;
      start = 1'b1; tick(); start = 1'b0;
      tick(); tick();
      if ({data, pc} !== {8'h41, 4'd2}) begin
         nmis++; $display("FAIL mem_retained got d=%h pc=%0d want 41 2", data, pc);
      end
      nvec++;
   endtask

   task automatic test_random();
      logic [13:0] w;
      int k;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         k = $urandom_range(0, 9);
         w = mk((k < 4) ? 2'b00 : (k < 7) ? 2'b01 : (k < 9) ? 2'b10 : 2'b11, 4'($urandom), 8'($urandom));
         load(4'(i), w);
      end
      for (int c = 0; c < 500; c++) begin
         reset     = ($urandom_range(0, 59) == 0);
         start     = ($urandom_range(0, 7) == 0);
         load_en   = ($urandom_range(0, 5) == 0);
         load_addr = 4'($urandom);
         k = $urandom_range(0, 9);
         load_word = mk((k < 4) ? 2'b00 : (k < 7) ? 2'b01 : (k < 9) ? 2'b10 : 2'b11, 4'($urandom), 8'($urandom));
         if ($urandom_range(0, 9) == 0) step_mode = ~step_mode;
         step = 1'($urandom);
         tick();
         if ({opcode, data, CALLproc, RET, busy, done, fault, pc} !==
             {e_op, e_data, e_call, e_ret, m_run, m_done, e_fault, e_pc}) begin
            nmis++;
            $display("FAIL random cyc=%0d got op=%h d=%h c=%b r=%b busy=%b done=%b f=%b pc=%0d want op=%h d=%h c=%b r=%b busy=%b done=%b f=%b pc=%0d",
                     c, opcode, data, CALLproc, RET, busy, done, fault, pc,
                     e_op, e_data, e_call, e_ret, m_run, m_done, e_fault, e_pc);
         end
         nvec++;
      end
      reset = 1'b0; start = 1'b0; load_en = 1'b0; step = 1'b0; step_mode = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mm[i] = 14'd0;
      reset = 1'b1; load_en = 1'b0; load_addr = 4'd0; load_word = 14'd0;
      start = 1'b0; step_mode = 1'b0; step = 1'b0;
      tick(); tick();
      test_reset();
      test_call_ret();
      test_overflow();
      test_underflow();
      test_step_mode();
      test_wrap_and_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter DEPTH, default 8: capacity of the downstream opcode stack, tracked here as a call depth.
REQ-002 Parameter PROG_WORDS, fixed at 16: number of program-memory entries, addressed by 4 bits.
REQ-003 clock  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 load_en  input  1  program-memory write strobe.
REQ-006 load_addr  input  4  program-memory write address.
REQ-007 load_word  input  14  instruction word: [13:12] kind, [11:8] opcode, [7:0] data.
REQ-008 start  input  1  begin execution at pc 0.
REQ-009 step_mode  input  1  1 = advance only on step.
REQ-010 step  input  1  single-step advance strobe.
REQ-011 opcode  output  4  opcode for a CALL; 0 otherwise.
REQ-012 data  output  8  data field of the issued instruction.
REQ-013 CALLproc  output  1  one-cycle push strobe to the downstream stage.
REQ-014 RET  output  1  one-cycle pop/execute strobe to the downstream stage.
REQ-015 busy  output  1  high in RUN.
REQ-016 done  output  1  high in DONE.
REQ-017 fault  output  2  00 none, 01 call overflow, 10 return underflow.
REQ-018 pc  output  4  address of the next instruction to issue.

Function
REQ-019 State machine with four states: IDLE, RUN, DONE, FAULT.
REQ-020 Program memory is 16x14 registers, written only in IDLE when load_en=1; load_en in any other state is ignored.
REQ-021 Program memory contents are not cleared by reset.
REQ-022 IDLE->RUN on the edge where start=1; that edge also sets pc=0 and depth=0.
REQ-023 A load_en and start in the same IDLE cycle both take effect; the write completes before the first fetch.
REQ-024 In RUN, an advance occurs at each edge when step_mode=0, and only at edges with step=1 when step_mode=1.
REQ-025 Each advance reads mem[pc] combinationally, registers the outputs, and increments pc modulo 16 (15 wraps to 0).
REQ-026 First strobe timing: with start at edge k and step_mode=0, the first instruction's outputs are visible after edge k+1.
REQ-027 Kind 00 (NOP): data=word[7:0], opcode=0, no strobe.
REQ-028 Kind 01 (CALL), depth<DEPTH: CALLproc=1, opcode=word[11:8], data=word[7:0], depth+1.
REQ-029 Kind 10 (RET), depth>0: RET=1, opcode=0, data=word[7:0], depth-1.
REQ-030 Kind 11 (HALT): RUN->DONE, no strobe, pc holds the HALT address +1.
REQ-031 CALL with depth==DEPTH: no strobe, RUN->FAULT, fault=01, pc not incremented.
REQ-032 RET with depth==0: no strobe, RUN->FAULT, fault=10, pc not incremented.
REQ-033 CALLproc and RET are high for exactly one cycle per advance; they are 0 in every non-advancing cycle, including RUN stall cycles under step_mode.
REQ-034 opcode and data return to 0 in cycles with no advance.
REQ-035 start while in RUN is ignored.
REQ-036 start in DONE restarts at pc=0, depth=0, and enters RUN.
REQ-037 FAULT is left only by reset; start in FAULT is ignored.
REQ-038 depth is an internal counter, 0..DEPTH, which never wraps.
REQ-039 step_mode may change at any cycle; it takes effect at the next edge.

Reset
REQ-040 reset=1 at an edge forces: state IDLE, pc=0, depth=0, opcode=0, data=0, CALLproc=0, RET=0, busy=0, done=0, fault=00.
REQ-041 Reset takes priority over all other inputs and applies in every state, including mid-RUN; no strobe is emitted in the cycle after a reset edge.

Verification
REQ-042 Load {0:CALL op=3 d=0x11, 1:RET d=0x22, 2:HALT}, start -> CALLproc=1 opcode=3 data=0x11, next cycle RET=1 opcode=0 data=0x22, next cycle done=1, pc=3.
REQ-043 Program of 9 consecutive CALLs with DEPTH=8 -> 8 CALLproc pulses, then fault=01, busy=0, pc=8.
REQ-044 First word is RET -> no RET pulse, fault=10, pc=0; a subsequent start is ignored; reset -> fault=00, state IDLE.
REQ-045 step_mode=1, step pulsed every 3rd cycle over a NOP,CALL,HALT program -> exactly one CALLproc pulse, aligned one cycle after the second step, with strobes 0 in all other cycles.
REQ-046 16 NOPs with no HALT -> pc sequence 0..15, 0, 1 while busy stays 1; reset asserted mid-run -> all outputs 0 on the next cycle, memory contents retained on reload-free restart.
